// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard: bypass
// select encodings, shadow-stage field widths and the per-source match result.
package hazard_scoreboard_unit_pkg;

   localparam int unsigned BYP_W       = 2;
   localparam int unsigned STG_VALID_W = 1;
   localparam int unsigned STG_WR_W    = 1;
   localparam int unsigned STG_LD_W    = 1;

   localparam logic [BYP_W-1:0] BYP_RF    = 2'b00;
   localparam logic [BYP_W-1:0] BYP_EXMEM = 2'b10;
   localparam logic [BYP_W-1:0] BYP_MEMWB = 2'b01;

   typedef struct packed {
      logic hit_ex;
      logic hit_ex_ld;
      logic hit_mem;
   } match_t;

   // Youngest producer wins; with forwarding disabled the regfile is always used.
   function automatic logic [BYP_W-1:0] byp_sel(input match_t m, input bit en);
      byp_sel = BYP_RF;
      if (en) begin
         if (m.hit_ex) begin
            byp_sel = BYP_EXMEM;
         end else if (m.hit_mem) begin
            byp_sel = BYP_MEMWB;
         end
      end
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage decode info in, pipeline control and EX bypass selects out.
interface hazard_scoreboard_unit_if
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int unsigned REG_W = 5
) ();

   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [REG_W-1:0] id_rd;
   logic             id_regwrite;
   logic             id_memread;
   logic             ex_branch_taken;
   logic             mem_wait;
   logic             stall;
   logic             flush;
   logic [BYP_W-1:0] bypassA;
   logic [BYP_W-1:0] bypassB;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
             id_regwrite, id_memread, ex_branch_taken, mem_wait,
      input  stall, flush, bypassA, bypassB
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
             id_regwrite, id_memread, ex_branch_taken, mem_wait,
      output stall, flush, bypassA, bypassB
   );

endinterface

// File: rtl/hazard_scoreboard_unit_match.sv
// Compares one ID source register against the EX and MEM shadow stages.
// Register 0 never matches since writes to it are discarded.
module hazard_match
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int unsigned REG_W = 5
) (
   input  logic                   use_src,
   input  logic [REG_W-1:0]       src,
   input  logic [STG_VALID_W-1:0] ex_valid,
   input  logic [STG_WR_W-1:0]    ex_wr,
   input  logic [REG_W-1:0]       ex_dest,
   input  logic [STG_LD_W-1:0]    ex_ld,
   input  logic [STG_VALID_W-1:0] mem_valid,
   input  logic [STG_WR_W-1:0]    mem_wr,
   input  logic [REG_W-1:0]       mem_dest,
   output match_t                 hit
);

   logic src_live;

   always_comb begin
      hit           = '0;
      src_live      = use_src && (src != '0);
      hit.hit_ex    = src_live && (ex_valid != '0) && (ex_wr != '0) && (ex_dest == src);
      hit.hit_ex_ld = hit.hit_ex && (ex_ld != '0);
      hit.hit_mem   = src_live && (mem_valid != '0) && (mem_wr != '0) && (mem_dest == src);
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: shadows EX/MEM/WB destinations, raises stall/flush
// combinationally and registers the EX operand bypass selects.
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int unsigned REG_W     = 5,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   hazard_scoreboard_unit_if.slave  bus
);

   typedef struct packed {
      logic [STG_VALID_W-1:0] valid;
      logic [STG_WR_W-1:0]    wr;
      logic [REG_W-1:0]       dest;
      logic [STG_LD_W-1:0]    ld;
   } stage_t;

   stage_t           s_ex;
   stage_t           s_mem;
   stage_t           s_wb;
   stage_t           id_stage;
   match_t           hit_a;
   match_t           hit_b;
   logic             hazard_c;
   logic [BYP_W-1:0] sel_a_c;
   logic [BYP_W-1:0] sel_b_c;

   hazard_match #(.REG_W(REG_W)) u_match_rs (
      .use_src   (bus.id_use_rs),
      .src       (bus.id_rs),
      .ex_valid  (s_ex.valid),
      .ex_wr     (s_ex.wr),
      .ex_dest   (s_ex.dest),
      .ex_ld     (s_ex.ld),
      .mem_valid (s_mem.valid),
      .mem_wr    (s_mem.wr),
      .mem_dest  (s_mem.dest),
      .hit       (hit_a)
   );

   hazard_match #(.REG_W(REG_W)) u_match_rt (
      .use_src   (bus.id_use_rt),
      .src       (bus.id_rt),
      .ex_valid  (s_ex.valid),
      .ex_wr     (s_ex.wr),
      .ex_dest   (s_ex.dest),
      .ex_ld     (s_ex.ld),
      .mem_valid (s_mem.valid),
      .mem_wr    (s_mem.wr),
      .mem_dest  (s_mem.dest),
      .hit       (hit_b)
   );

   // Invalid ID slots enter EX as an all-zero bubble so stale fields never linger.
   always_comb begin
      id_stage = '0;
      hazard_c = 1'b0;
      if (bus.id_valid) begin
         id_stage.valid = 1'b1;
         id_stage.wr    = bus.id_regwrite;
         id_stage.dest  = bus.id_rd;
         id_stage.ld    = bus.id_memread;
      end
      hazard_c = bus.id_valid &&
                 (hit_a.hit_ex_ld || hit_b.hit_ex_ld ||
                  (!BYPASS_EN && (hit_a.hit_ex || hit_a.hit_mem ||
                                  hit_b.hit_ex || hit_b.hit_mem)));
      sel_a_c  = byp_sel(hit_a, BYPASS_EN);
      sel_b_c  = byp_sel(hit_b, BYPASS_EN);
   end

   // A taken branch kills the ID instruction, so its data hazard is moot.
   assign bus.stall = !reset && (bus.mem_wait || (!bus.ex_branch_taken && hazard_c));
   assign bus.flush = !reset && bus.ex_branch_taken && !bus.mem_wait;

   always_ff @(posedge clock) begin
      if (reset) begin
         s_ex        <= '0;
         s_mem       <= '0;
         s_wb        <= '0;
         bus.bypassA <= BYP_RF;
         bus.bypassB <= BYP_RF;
      end else if (!bus.mem_wait) begin
         s_wb  <= s_mem;
         s_mem <= s_ex;
         if (bus.flush || bus.stall) begin
            s_ex        <= '0;
            bus.bypassA <= BYP_RF;
            bus.bypassB <= BYP_RF;
         end else begin
            s_ex        <= id_stage;
            bus.bypassA <= sel_a_c;
            bus.bypassB <= sel_b_c;
         end
      end
   end

   // WB needs no bypass (write-first regfile); keep its bubbles canonical.
   a_wb_bubble_clean: assert property (
      @(posedge clock) disable iff (reset)
      (s_wb.valid == '0) |-> (s_wb == '0)
   );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit: one forwarding instance
// and one BYPASS_EN=0 instance sharing clock and reset.
module tb_hazard_scoreboard_unit;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   hazard_scoreboard_unit_if #(.REG_W(5)) bus    ();
   hazard_scoreboard_unit_if #(.REG_W(5)) bus_nb ();

   hazard_scoreboard_unit #(.REG_W(5), .BYPASS_EN(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   hazard_scoreboard_unit #(.REG_W(5), .BYPASS_EN(1'b0)) dut_nb (
      .clock (clock),
      .reset (reset),
      .bus   (bus_nb.slave)
   );

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic id_set(input int v, input int rs, input int rt, input int urs,
                         input int urt, input int rd, input int wr, input int mr);
      bus.id_valid    = 1'(v);
      bus.id_rs       = 5'(rs);
      bus.id_rt       = 5'(rt);
      bus.id_use_rs   = 1'(urs);
      bus.id_use_rt   = 1'(urt);
      bus.id_rd       = 5'(rd);
      bus.id_regwrite = 1'(wr);
      bus.id_memread  = 1'(mr);
      #1;
   endtask

   task automatic id_set_nb(input int v, input int rs, input int rt, input int urs,
                            input int urt, input int rd, input int wr, input int mr);
      bus_nb.id_valid    = 1'(v);
      bus_nb.id_rs       = 5'(rs);
      bus_nb.id_rt       = 5'(rt);
      bus_nb.id_use_rs   = 1'(urs);
      bus_nb.id_use_rt   = 1'(urt);
      bus_nb.id_rd       = 5'(rd);
      bus_nb.id_regwrite = 1'(wr);
      bus_nb.id_memread  = 1'(mr);
      #1;
   endtask

   task automatic drain();
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
   endtask

   initial begin
      bus.ex_branch_taken    = 1'b1;
      bus.mem_wait           = 1'b1;
      bus_nb.ex_branch_taken = 1'b0;
      bus_nb.mem_wait        = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      id_set_nb(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset: outputs quiet even with mem_wait and branch asserted
      repeat (2) step();
      chk("rst_stall", {1'b0, bus.stall}, 2'b00);
      chk("rst_flush", {1'b0, bus.flush}, 2'b00);
      chk("rst_bypA", bus.bypassA, 2'b00);
      chk("rst_bypB", bus.bypassB, 2'b00);
      bus.ex_branch_taken = 1'b0;
      bus.mem_wait        = 1'b0;
      reset               = 1'b0;
      #1;

      // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A
      id_set(1, 1, 2, 1, 1, 3, 1, 0);
      chk("t1_add_stall", {1'b0, bus.stall}, 2'b00);
      step();
      id_set(1, 3, 5, 1, 1, 4, 1, 0);
      chk("t1_sub_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t1_bypA", bus.bypassA, 2'b10);
      chk("t1_bypB", bus.bypassB, 2'b00);
      drain();

      // add $3 ; nop ; or $6,$7,$3 -> MEM/WB forward on B
      id_set(1, 1, 2, 1, 1, 3, 1, 0);
      step();
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      id_set(1, 7, 3, 1, 1, 6, 1, 0);
      chk("t2_or_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t2_bypA", bus.bypassA, 2'b00);
      chk("t2_bypB", bus.bypassB, 2'b01);
      drain();

      // lw $8,0($9) ; add $10,$8,$8 -> one bubble then MEM/WB on both
      id_set(1, 9, 0, 1, 0, 8, 1, 1);
      step();
      id_set(1, 8, 8, 1, 1, 10, 1, 0);
      chk("t3_lu_stall", {1'b0, bus.stall}, 2'b01);
      chk("t3_lu_flush", {1'b0, bus.flush}, 2'b00);
      step();
      chk("t3_stall_drop", {1'b0, bus.stall}, 2'b00);
      chk("t3_bubble_bypA", bus.bypassA, 2'b00);
      step();
      chk("t3_bypA", bus.bypassA, 2'b01);
      chk("t3_bypB", bus.bypassB, 2'b01);
      drain();

      // add $3 ; add $3 ; sub $4,$3,$3 -> youngest wins; $0 never forwards
      id_set(1, 1, 2, 1, 1, 3, 1, 0);
      step();
      id_set(1, 1, 2, 1, 1, 3, 1, 0);
      step();
      id_set(1, 3, 3, 1, 1, 4, 1, 0);
      chk("t4_sub_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t4_bypA", bus.bypassA, 2'b10);
      chk("t4_bypB", bus.bypassB, 2'b10);
      id_set(1, 1, 2, 1, 1, 0, 1, 1);
      step();
      id_set(1, 0, 0, 1, 1, 5, 1, 0);
      chk("t4_r0_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t4_r0_bypA", bus.bypassA, 2'b00);
      chk("t4_r0_bypB", bus.bypassB, 2'b00);
      drain();

      // lw-use with a taken branch -> flush wins, the consumer is killed
      id_set(1, 9, 0, 1, 0, 8, 1, 1);
      step();
      id_set(1, 8, 8, 1, 1, 10, 1, 0);
      bus.ex_branch_taken = 1'b1;
      #1;
      chk("t5_flush", {1'b0, bus.flush}, 2'b01);
      chk("t5_stall", {1'b0, bus.stall}, 2'b00);
      step();
      bus.ex_branch_taken = 1'b0;
      chk("t5_bubble_bypA", bus.bypassA, 2'b00);
      id_set(1, 10, 8, 1, 1, 11, 1, 0);
      chk("t5_next_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t5_killed_bypA", bus.bypassA, 2'b00);
      chk("t5_lw_bypB", bus.bypassB, 2'b01);
      drain();

      // mem_wait for 3 cycles holds state and selects; result matches no-wait run
      id_set(1, 1, 2, 1, 1, 3, 1, 0);
      step();
      id_set(1, 3, 5, 1, 1, 4, 1, 0);
      step();
      id_set(1, 4, 3, 1, 1, 6, 1, 0);
      bus.mem_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.ex_branch_taken = (i == 1);
         #1;
         chk("t6_wait_stall", {1'b0, bus.stall}, 2'b01);
         chk("t6_wait_flush", {1'b0, bus.flush}, 2'b00);
         step();
         chk("t6_hold_bypA", bus.bypassA, 2'b10);
         chk("t6_hold_bypB", bus.bypassB, 2'b00);
      end
      bus.mem_wait        = 1'b0;
      bus.ex_branch_taken = 1'b0;
      #1;
      chk("t6_release_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t6_bypA", bus.bypassA, 2'b10);
      chk("t6_bypB", bus.bypassB, 2'b01);
      drain();

      // Reset in the middle of a load-use stall
      id_set(1, 9, 0, 1, 0, 8, 1, 1);
      step();
      id_set(1, 8, 8, 1, 1, 10, 1, 0);
      chk("t7_pre_stall", {1'b0, bus.stall}, 2'b01);
      reset = 1'b1;
      #1;
      chk("t7_rst_stall", {1'b0, bus.stall}, 2'b00);
      step();
      reset = 1'b0;
      #1;
      chk("t7_empty_stall", {1'b0, bus.stall}, 2'b00);
      step();
      chk("t7_bypA", bus.bypassA, 2'b00);
      chk("t7_bypB", bus.bypassB, 2'b00);
      drain();

      // No-forwarding instance: add $3 ; sub $4,$3,$1 -> two stall cycles
      id_set_nb(1, 1, 2, 1, 1, 3, 1, 0);
      step();
      id_set_nb(1, 3, 1, 1, 1, 4, 1, 0);
      chk("nb_stall_ex", {1'b0, bus_nb.stall}, 2'b01);
      step();
      chk("nb_stall_mem", {1'b0, bus_nb.stall}, 2'b01);
      chk("nb_bubble_bypA", bus_nb.bypassA, 2'b00);
      step();
      chk("nb_stall_wb", {1'b0, bus_nb.stall}, 2'b00);
      step();
      chk("nb_bypA", bus_nb.bypassA, 2'b00);
      chk("nb_bypB", bus_nb.bypassB, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline's separate bypass and stall detectors for the 5-stage MIPS core.
- Merges both functions into one sequential unit. It keeps its own shadow copy of the destination info for the EX, MEM and WB stages.
- Generates registered bypass selects plus combinational stall and flush. Adds the functions the earlier logic lacked:
  - branch flush
  - memory-wait freeze
  - a no-forwarding mode.
- Sits in ID, beside the main control decoder. Its outputs drive the top-level pipeline-register enables and the EX operand muxes.

Parameters:
- REG_W, 5, register-index width; register-file size is 2**REG_W.
- BYPASS_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = stall until the producer reaches WB.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source A index
- id_rt  in  REG_W  source B index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_rd  in  REG_W  destination, after the RegDst mux
- id_regwrite  in  1  instruction writes a register
- id_memread  in  1  instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_wait  in  1  data memory not ready; freeze whole pipeline
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
- flush  out  1  zero IF/ID and ID/EX (combinational)
- bypassA  out  2  EX operand-A select (registered): 00 regfile, 10 EX/MEM, 01 MEM/WB
- bypassB  out  2  EX operand-B select (registered), same encoding

Behaviour:
- Shadow state: S_EX, S_MEM, S_WB, each holding {valid, wr, dest, ld}.
- Reset: all valid=0, bypassA=bypassB=00; stall=flush=0 while reset is high.
- A source "matches" a stage when: use bit set, index != 0, stage valid & wr, and dest == index.
- Register file is write-first, so a match in S_WB never needs a bypass or a stall.
- stall is asserted when any of these holds:
  - mem_wait=1;
  - id_valid and a source matches S_EX with ld=1 (load-use; 1 bubble);
  - BYPASS_EN=0, id_valid, and a source matches S_EX or S_MEM.
- flush = ex_branch_taken & ~mem_wait.
- Priority: mem_wait > flush > stall.
  - A taken branch suppresses the load-use stall, because the ID instruction is killed.
- Every rising edge, in priority order:
  - reset: clear all state (see above).
  - mem_wait: hold all state and the bypass outputs.
  - Otherwise advance: S_WB<=S_MEM, S_MEM<=S_EX.
    - If flush or stall, S_EX<=bubble (valid=0) and bypassA/B<=00.
    - Else S_EX<={id_valid, id_regwrite, id_rd, id_memread}, and bypassA/B<=the ID-computed select.
- Select per source, with the youngest producer winning:
  - match S_EX -> 10
  - else match S_MEM -> 01
  - else 00
  - When BYPASS_EN=0 the select is always 00.
- Latency: a select is computed in ID and presented in the cycle the consumer occupies EX.
- Writes to register 0 never create hazards.
- Reset mid-stall: stall drops in the same cycle and the pipeline restarts empty.

Decomposition:
- Shared constants header gains:
  - BYP_RF=2'b00, BYP_EXMEM=2'b10, BYP_MEMWB=2'b01
  - the shadow-stage field widths.
- One natural sub-module: hazard_match, a combinational per-source comparator. It is instantiated twice (rs, rt) and returns {hit_ex, hit_ex_ld, hit_mem}.

Test Plan:
- Default parameters. add $3,$1,$2 then sub $4,$3,$5 -> sub in EX with bypassA=10, no stall.
- Default parameters. add $3 ; nop ; or $6,$7,$3 -> or in EX with bypassB=01.
- Default parameters. lw $8,0($9) ; add $10,$8,$8 -> stall=1 for exactly 1 cycle, then bypassA=bypassB=01 in EX.
- Default parameters. add $3 ; add $3 ; sub $4,$3,$3 -> selects 10 (youngest producer); a write to $0 followed by a read of $0 -> 00, no stall.
- Default parameters. lw-use pair with ex_branch_taken=1 in the stall cycle -> flush=1, stall=0, bubble in S_EX.
- Default parameters. mem_wait held 3 cycles mid-sequence -> state and bypass frozen, results identical to the no-wait run.
- BYPASS_EN=0. add $3 ; sub $4,$3,$1 -> 2 stall cycles, bypassA=00.
